// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner for the pill dispenser.
// Drives a one-hot column scan and samples the synchronized rows once per column.
// Each full scan is classified as none, single or multi.
// Single presses and releases are debounced over whole scans.
// Each accepted key is handed off through a valid/ack handshake.
module keypad_scan_ctrl #(
   parameter int CLK_DIV        = 4096,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [3:0] filas,
   output logic [3:0] columnas,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ack,
   output logic       key_held,
   output logic       overrun
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] DEB_N    = CW'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD} state_e;

   logic [3:0]    filas_s1_q, filas_s1_d, filas_s2_q, filas_s2_d;
   logic          run_q, run_d;
   logic [DW-1:0] div_q, div_d;
   logic [1:0]    col_q, col_d;
   logic [1:0]    acc_n_q, acc_n_d;      // hits so far this scan, saturates at 2
   logic [3:0]    acc_code_q, acc_code_d;
   state_e        state_q, state_d;
   logic [3:0]    cand_q, cand_d;
   logic [CW-1:0] cnt_q, cnt_d, rel_q, rel_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_valid_q, key_valid_d;
   logic          overrun_q, overrun_d;

   logic          tick, scan_end, accept;
   logic [2:0]    row_cnt, hit_sum;
   logic [1:0]    row_idx, scan_n;
   logic [3:0]    scan_code, accept_code;

   // Scan is gated until one edge after enable, so column 0 gets a full dwell
   assign tick     = run_q & enable & (div_q == DIV_LAST);
   assign scan_end = tick & (col_q == 2'd3);

   // Classify the current column's rows and fold them into the scan result
   always_comb begin
      row_cnt = {2'b00, filas_s2_q[0]} + {2'b00, filas_s2_q[1]} +
                {2'b00, filas_s2_q[2]} + {2'b00, filas_s2_q[3]};
      row_idx = 2'd0;
      for (int r = 3; r >= 0; r--)
         if (filas_s2_q[r]) row_idx = 2'(r);
      hit_sum   = {1'b0, acc_n_q} + row_cnt;
      scan_n    = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
      scan_code = (acc_n_q == 2'd0 && row_cnt == 3'd1) ? {row_idx, col_q} : acc_code_q;
   end

   // Divider, column index, synchronizer and per-scan accumulator next values
   always_comb begin
      filas_s1_d = filas;
      filas_s2_d = filas_s1_q;
      run_d      = enable;
      div_d      = div_q;
      col_d      = col_q;
      acc_n_d    = acc_n_q;
      acc_code_d = acc_code_q;
      if (!enable) begin
         div_d      = '0;
         col_d      = 2'd0;
         acc_n_d    = 2'd0;
         acc_code_d = 4'd0;
      end else if (run_q) begin
         if (tick) begin
            div_d      = '0;
            col_d      = col_q + 2'd1;
            acc_n_d    = scan_end ? 2'd0 : scan_n;
            acc_code_d = scan_end ? 4'd0 : scan_code;
         end else begin
            div_d = div_q + DW'(1);
         end
      end
   end

   // Scan datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filas_s1_q <= 4'd0;
         filas_s2_q <= 4'd0;
         run_q      <= 1'b0;
         div_q      <= '0;
         col_q      <= 2'd0;
         acc_n_q    <= 2'd0;
         acc_code_q <= 4'd0;
      end else begin
         filas_s1_q <= filas_s1_d;
         filas_s2_q <= filas_s2_d;
         run_q      <= run_d;
         div_q      <= div_d;
         col_q      <= col_d;
         acc_n_q    <= acc_n_d;
         acc_code_q <= acc_code_d;
      end
   end

   // FSM state register with debounce counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_SCAN;
         cand_q  <= 4'd0;
         cnt_q   <= '0;
         rel_q   <= '0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         rel_q   <= rel_d;
      end
   end

   // FSM next state, evaluated only on the tick that closes a full scan
   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      rel_d       = rel_q;
      accept      = 1'b0;
      accept_code = cand_q;
      if (!enable) begin
         state_d = ST_SCAN;
         cnt_d   = '0;
         rel_d   = '0;
      end else if (scan_end) begin
         case (state_q)
            ST_SCAN: begin
               if (scan_n == 2'd1) begin
                  cand_d      = scan_code;
                  cnt_d       = CW'(1);
                  accept_code = scan_code;
                  if (DEBOUNCE_SCANS == 1) begin
                     accept  = 1'b1;
                     state_d = ST_HELD;
                     rel_d   = '0;
                  end else begin
                     state_d = ST_DEBOUNCE;
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (scan_n == 2'd1 && scan_code == cand_q) begin
                  cnt_d = cnt_q + CW'(1);
                  if (cnt_q + CW'(1) == DEB_N) begin
                     accept  = 1'b1;
                     state_d = ST_HELD;
                     rel_d   = '0;
                  end
               end else begin
                  state_d = ST_SCAN;
                  cnt_d   = '0;
               end
            end
            ST_HELD: begin
               if (scan_n == 2'd0) begin
                  if (rel_q + CW'(1) == DEB_N) begin
                     state_d = ST_SCAN;
                     rel_d   = '0;
                  end else begin
                     rel_d = rel_q + CW'(1);
                  end
               end else begin
                  rel_d = '0;
               end
            end
            default: state_d = ST_SCAN;
         endcase
      end
   end

   // Handshake outputs: an accept beats a same-cycle ack, otherwise it overruns
   always_comb begin
      key_code_d  = key_code_q;
      key_valid_d = key_valid_q;
      overrun_d   = 1'b0;
      if (accept) begin
         if (!key_valid_q || key_ack) begin
            key_code_d  = accept_code;
            key_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (key_ack) begin
         key_valid_d = 1'b0;
      end
   end

   // Handshake output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_code_q  <= 4'd0;
         key_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign columnas  = (run_q && enable) ? (4'b0001 << col_q) : 4'b0000;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = (state_q == ST_HELD);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: emulates a 4x4 key matrix and drives the DUT with scan-aligned presses.
// Results are compared scan by scan against a scan-level model of the debounce and handshake rules.
module tb_keypad_scan_ctrl;

   localparam int CD = 4;
   localparam int DS = 3;
   localparam int SC = 4 * CD;

   logic        clk = 1'b0;
   logic        rst_n, enable, key_ack;
   logic [3:0]  filas, columnas, key_code;
   logic        key_valid, key_held, overrun;
   logic [15:0] pressed;

   int checks = 0;
   int errors = 0;

   // scan-level reference model state
   int          m_st, m_cand, m_cnt, m_rel;
   logic        m_valid, m_ov;
   logic [3:0]  m_code;

   keypad_scan_ctrl #(.CLK_DIV(CD), .DEBOUNCE_SCANS(DS)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .filas(filas),
      .columnas(columnas), .key_code(key_code), .key_valid(key_valid),
      .key_ack(key_ack), .key_held(key_held), .overrun(overrun));

   always #5 clk = ~clk;

   // key matrix: row r reads high when a pressed key in row r sits on a driven column
   always_comb begin
      filas = 4'd0;
      for (int r = 0; r < 4; r++) filas[r] = |(pressed[4*r +: 4] & columnas);
   end

   task automatic mdl_reset();
      m_st = 0; m_cand = 0; m_cnt = 0; m_rel = 0;
      m_valid = 1'b0; m_ov = 1'b0; m_code = 4'd0;
   endtask

   // one full scan of the model: 0=SCAN 1=DEBOUNCE 2=HELD
   task automatic mdl_scan(input logic [15:0] mask, input int ack_off);
      int pc, idx;
      bit acc;
      pc = $countones(mask);
      idx = 0;
      for (int k = 0; k < 16; k++) if (mask[k]) idx = k;
      if (ack_off >= 0 && ack_off < SC - 1) m_valid = 1'b0;
      acc = 0;
      m_ov = 1'b0;
      case (m_st)
         0: if (pc == 1) begin
               m_cand = idx; m_cnt = 1;
               if (DS == 1) begin acc = 1; m_st = 2; m_rel = 0; end
               else m_st = 1;
            end
         1: if (pc == 1 && idx == m_cand) begin
               m_cnt++;
               if (m_cnt == DS) begin acc = 1; m_st = 2; m_rel = 0; end
            end else begin
               m_st = 0; m_cnt = 0;
            end
         default: if (pc == 0) begin
               m_rel++;
               if (m_rel == DS) begin m_st = 0; m_rel = 0; end
            end else m_rel = 0;
      endcase
      if (acc) begin
         if (!m_valid || ack_off == SC - 1) begin
            m_code = 4'(m_cand);
            m_valid = 1'b1;
         end else m_ov = 1'b1;
      end else if (ack_off == SC - 1) m_valid = 1'b0;
   endtask

   // drive one aligned scan (starts #1 after a col-0 edge) and compare with the model
   task automatic scan(input logic [15:0] mask, input int ack_off);
      int ov_seen;
      ov_seen = 0;
      pressed = mask;
      for (int i = 0; i < SC; i++) begin
         key_ack = (i == ack_off);
         @(posedge clk); #1;
         if (overrun === 1'b1) ov_seen++;
      end
      key_ack = 1'b0;
      mdl_scan(mask, ack_off);
      checks += 4;
      if (key_valid !== m_valid) begin
         errors++; $display("FAIL scan_valid mask=%h got %b exp %b", mask, key_valid, m_valid);
      end
      if (key_code !== m_code) begin
         errors++; $display("FAIL scan_code mask=%h got %0d exp %0d", mask, key_code, m_code);
      end
      if (key_held !== (m_st == 2)) begin
         errors++; $display("FAIL scan_held mask=%h got %b exp %b", mask, key_held, m_st == 2);
      end
      if (ov_seen != int'(m_ov)) begin
         errors++; $display("FAIL scan_overrun mask=%h got %0d cycles exp %0d", mask, ov_seen, m_ov);
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp;
      rst_n = 1'b0; enable = 1'b1; key_ack = 1'b0; pressed = 16'd0;
      mdl_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({columnas, key_code, key_valid, key_held, overrun} !== 11'd0) begin
         errors++; $display("FAIL reset_outputs got %b exp 0", {columnas, key_code, key_valid, key_held, overrun});
      end
      rst_n = 1'b1;
      for (int i = 0; i <= 2 * SC; i++) begin
         @(posedge clk); #1;
         exp = 4'b0001 << ((i / CD) % 4);
         checks++;
         if (columnas !== exp) begin
            errors++; $display("FAIL scan_seq cycle %0d got %b exp %b", i, columnas, exp);
         end
      end
   endtask

   task automatic test_single_press();
      int rise_at, rises;
      logic prev;
      rise_at = -1; rises = 0; prev = key_valid;
      for (int s = 0; s < 20; s++) begin
         scan(16'd1 << 9, -1);
         if (key_valid && !prev) begin rises++; if (rise_at < 0) rise_at = s + 1; end
         prev = key_valid;
      end
      checks += 3;
      if (rises != 1) begin errors++; $display("FAIL single_rises got %0d exp 1", rises); end
      if (rise_at < DS || rise_at > DS + 1) begin
         errors++; $display("FAIL single_latency got %0d scans exp %0d..%0d", rise_at, DS, DS + 1);
      end
      if (key_code !== 4'd9 || key_held !== 1'b1) begin
         errors++; $display("FAIL single_code got code %0d held %b exp 9 1", key_code, key_held);
      end
      for (int s = 0; s < DS; s++) scan(16'd0, -1);
      checks++;
      if (key_held !== 1'b0) begin errors++; $display("FAIL single_release got %b exp 0", key_held); end
   endtask

   task automatic test_bounce();
      int rises;
      scan(16'd0, 0);
      rises = 0;
      scan(16'd1 << 6, -1); if (key_valid) rises++;
      scan(16'd0, -1);      if (key_valid) rises++;
      scan(16'd1 << 6, -1); if (key_valid) rises++;
      scan(16'd1 << 6, -1); if (key_valid) rises++;
      scan(16'd0, -1);      if (key_valid) rises++;
      scan(16'd0, -1);      if (key_valid) rises++;
      checks++;
      if (rises != 0) begin errors++; $display("FAIL bounce_valid got %0d scans valid exp 0", rises); end
   endtask

   task automatic test_multi();
      int bad;
      bad = 0;
      for (int s = 0; s < 10; s++) begin
         scan(16'h0009, -1);
         if (key_valid || key_held) bad++;
      end
      scan(16'd0, -1);
      checks++;
      if (bad != 0) begin errors++; $display("FAIL multi_reject got %0d bad scans exp 0", bad); end
   endtask

   task automatic test_overrun_handshake();
      for (int s = 0; s < DS; s++) scan(16'd0, (s == 0) ? 0 : -1);
      for (int s = 0; s < DS; s++) scan(16'd1 << 5, -1);
      for (int s = 0; s < DS; s++) scan(16'd0, -1);
      for (int s = 0; s < DS; s++) scan(16'd1 << 14, -1);
      checks++;
      if (key_code !== 4'd5 || key_valid !== 1'b1) begin
         errors++; $display("FAIL overrun_keep got code %0d valid %b exp 5 1", key_code, key_valid);
      end
      for (int s = 0; s < DS; s++) scan(16'd0, -1);
      for (int s = 0; s < DS; s++) scan(16'd1 << 3, (s == DS - 1) ? SC - 1 : -1);
      checks++;
      if (key_code !== 4'd3 || key_valid !== 1'b1) begin
         errors++; $display("FAIL ack_accept_same got code %0d valid %b exp 3 1", key_code, key_valid);
      end
      scan(16'd0, 2);
      checks++;
      if (key_valid !== 1'b0) begin errors++; $display("FAIL ack_clear got %b exp 0", key_valid); end
      for (int s = 1; s < DS; s++) scan(16'd0, -1);
   endtask

   task automatic test_enable();
      int bad;
      scan(16'd0, 0);
      scan(16'd1 << 6, -1);
      scan(16'd1 << 6, -1);
      repeat (5) @(posedge clk);
      #1;
      enable = 1'b0;
      #1;
      checks++;
      if (columnas !== 4'd0) begin errors++; $display("FAIL enable_cols_now got %b exp 0", columnas); end
      m_st = 0; m_cnt = 0; m_rel = 0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (columnas !== 4'd0 || key_held !== 1'b0 || key_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL enable_low got %0d bad cycles exp 0", bad); end
      enable = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (columnas !== 4'b0001) begin errors++; $display("FAIL enable_restart got %b exp 0001", columnas); end
      scan(16'd1 << 6, -1);
      scan(16'd1 << 6, -1);
      scan(16'd0, -1);
      checks++;
      if (key_valid !== 1'b0) begin errors++; $display("FAIL enable_no_accept got %b exp 0", key_valid); end
   endtask

   task automatic test_reset_mid();
      for (int s = 0; s < DS + 1; s++) scan(16'd1 << 12, -1);
      checks++;
      if (key_held !== 1'b1 || key_code !== 4'd12) begin
         errors++; $display("FAIL pre_reset got held %b code %0d exp 1 12", key_held, key_code);
      end
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({columnas, key_code, key_valid, key_held, overrun} !== 11'd0) begin
         errors++; $display("FAIL async_reset got %b exp 0", {columnas, key_code, key_valid, key_held, overrun});
      end
      mdl_reset();
      pressed = 16'd0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (columnas !== 4'b0001) begin errors++; $display("FAIL reset_restart got %b exp 0001", columnas); end
   endtask

   task automatic test_random();
      logic [15:0] mask;
      int kind, len, a, b;
      for (int blk = 0; blk < 14; blk++) begin
         kind = $urandom_range(0, 3);
         len  = $urandom_range(1, 5);
         a = $urandom_range(0, 15);
         b = (a + $urandom_range(1, 15)) % 16;
         case (kind)
            0:       mask = 16'd0;
            3:       mask = (16'd1 << a) | (16'd1 << b);
            default: mask = 16'd1 << a;
         endcase
         for (int s = 0; s < len; s++)
            scan(mask, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, SC - 1)) : -1);
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_multi();
      test_overrun_handshake();
      test_enable();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout after 2ms sim time");
      $fatal(1, "timeout");
   end

endmodule
